// File: rtl/m2vpxrd.sv
// Pixel reader/reconstruction behind the MPEG2 IDCT: walks the 32-word pixel port,
// adds prediction (non-intra), clips to 0..255 and streams words through a small skid buffer.
module m2vpxrd #(
  parameter int RD_LAT     = 1,
  parameter int SKID_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        softreset,
  input  logic        blk_start,
  input  logic        blk_coded,
  input  logic        blk_intra,
  output logic        busy,
  output logic        pixel_coded,
  output logic [4:0]  pixel_addr,
  input  logic [8:0]  pixel_data0,
  input  logic [8:0]  pixel_data1,
  input  logic        pred_valid,
  output logic        pred_ready,
  input  logic [15:0] pred_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        done
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(SKID_DEPTH);

  if (RD_LAT != 1 || SKID_DEPTH < RD_LAT + 1) begin : g_bad_cfg
    $error("m2vpxrd: unsupported RD_LAT/SKID_DEPTH combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                       state_q, state_d;
  logic                         busy_q, busy_d, coded_q, coded_d, intra_q, intra_d;
  logic                         done_q, done_d;
  logic [4:0]                   addr_q, addr_d;
  logic                         inf_q, inf_d, inf_last_q, inf_last_d;
  logic [15:0]                  pred_q, pred_d;
  logic [SKID_DEPTH-1:0][16:0]  mem_q, mem_d;  // {last, data}
  logic [PW-1:0]                rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic        issue, pop, push;
  logic [CW:0] occ;
  logic [16:0] wdata;

  function automatic logic [7:0] clip8(input logic [8:0] r, input logic [7:0] p);
    logic [9:0] s;
    s = {r[8], r} + {2'b00, p};
    if (s[9])      return 8'h00;
    else if (s[8]) return 8'hff;
    else           return s[7:0];
  endfunction

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = inf_q;
  // Space freed by a pop in this cycle counts, so a full pipe still sustains one word per cycle.
  assign occ       = (CW+1)'(inf_q) + (CW+1)'(cnt_q) - (CW+1)'(pop);
  assign issue     = (state_q == RUN) && (occ < DEPTH_C) && (intra_q || pred_valid);
  assign wdata     = {inf_last_q, clip8(pixel_data1, pred_q[15:8]), clip8(pixel_data0, pred_q[7:0])};

  assign busy        = busy_q;
  assign pixel_coded = coded_q;
  assign pixel_addr  = addr_q;
  assign pred_ready  = issue && !intra_q;
  assign out_data    = out_valid ? mem_q[rd_q][15:0] : 16'h0000;
  assign out_last    = out_valid && mem_q[rd_q][16];
  assign done        = done_q;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    coded_d    = coded_q;
    intra_d    = intra_q;
    done_d     = 1'b0;
    addr_d     = addr_q;
    inf_d      = issue;
    inf_last_d = issue && (addr_q == 5'd31);
    pred_d     = pred_q;
    mem_d      = mem_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    if (issue) begin
      addr_d = addr_q + 5'd1;
      pred_d = intra_q ? 16'h0000 : pred_data;
    end
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d = (wr_q == PW'(SKID_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (pop) rd_d = (rd_q == PW'(SKID_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case (state_q)
      IDLE: if (blk_start && !done_q) begin
        state_d = RUN;
        busy_d  = 1'b1;
        coded_d = blk_coded;
        intra_d = blk_intra;
        addr_d  = '0;
      end
      RUN:   if (issue && addr_q == 5'd31) state_d = DRAIN;
      DRAIN: if (pop && out_last) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || softreset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      coded_q    <= 1'b0;
      intra_q    <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      inf_q      <= 1'b0;
      inf_last_q <= 1'b0;
      pred_q     <= '0;
      mem_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      coded_q    <= coded_d;
      intra_q    <= intra_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      inf_q      <= inf_d;
      inf_last_q <= inf_last_d;
      pred_q     <= pred_d;
      mem_q      <= mem_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_m2vpxrd.sv
// Randomized bench for m2vpxrd: IDCT and prediction sources modelled here, words checked
// against a per-index arithmetic reference (residual + prediction, clipped).
module tb_m2vpxrd;
  logic        clk = 1'b0;
  logic        reset, softreset, blk_start, blk_coded, blk_intra;
  logic        busy, pixel_coded, pred_valid, pred_ready, out_valid, out_ready, out_last, done;
  logic [4:0]  pixel_addr;
  logic [8:0]  pixel_data0, pixel_data1;
  logic [15:0] pred_data, out_data;

  always #5 clk = ~clk;

  m2vpxrd dut (
    .clk(clk), .reset(reset), .softreset(softreset), .blk_start(blk_start),
    .blk_coded(blk_coded), .blk_intra(blk_intra), .busy(busy), .pixel_coded(pixel_coded),
    .pixel_addr(pixel_addr), .pixel_data0(pixel_data0), .pixel_data1(pixel_data1),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_data(pred_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  int total = 0, bad = 0;
  int res0[32], res1[32], pl[32], ph[32];
  logic [15:0] got_d[$];
  logic        got_l[$];
  int          iss[$], stall_addr[$];
  int first_valid, first_acc, last_cyc, done_cyc, done_cnt, busy_at_done, busy_gap;
  int bad_pr, stab_bad, max_occ, stall_pr, nacc, pidx;
  bit timeout;

  function automatic int clipv(input int s);
    return (s < 0) ? 0 : ((s > 255) ? 255 : s);
  endfunction

  // Expected output word k: residual (0 when uncoded) plus prediction (0 when intra), clipped.
  function automatic logic [15:0] model_word(input int k, input bit intra, input bit coded);
    int lo, hi;
    lo = clipv((coded ? res0[k] : 0) + (intra ? 0 : pl[k]));
    hi = clipv((coded ? res1[k] : 0) + (intra ? 0 : ph[k]));
    return 16'(hi * 256 + lo);
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 32; k++) begin
      res0[k] = int'($urandom_range(0, 511)) - 256;
      res1[k] = int'($urandom_range(0, 511)) - 256;
      pl[k]   = int'($urandom_range(0, 255));
      ph[k]   = int'($urandom_range(0, 255));
    end
  endtask

  // Drives one block and records what the DUT did; the calling test does the comparing.
  task automatic run_block(input bit intra, input bit coded, input int rmode, input bit pv_rand,
                           input int stall_at, input int abort_at, input bit extra_start);
    int cyc, addr_cap, stall_left;
    bit coded_cap, hold, stall_used, stalled, finished;
    logic [15:0] hd;
    logic hl;
    got_d.delete(); got_l.delete(); iss.delete(); stall_addr.delete();
    first_valid = -1; first_acc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
    busy_at_done = -1; busy_gap = 0; bad_pr = 0; stab_bad = 0; max_occ = 0; stall_pr = 0;
    nacc = 0; pidx = 0; hold = 0; stall_left = 0; stall_used = 0; finished = 0;
    @(posedge clk); #1;
    blk_start = 1'b1; blk_coded = coded; blk_intra = intra; out_ready = 1'b1; pred_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    addr_cap = pixel_addr; coded_cap = pixel_coded;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      cyc++;
      blk_start = extra_start && (cyc == 3);
      blk_coded = 1'($urandom_range(0, 1));
      blk_intra = 1'($urandom_range(0, 1));
      pixel_data0 = coded_cap ? 9'(res0[addr_cap]) : 9'd0;
      pixel_data1 = coded_cap ? 9'(res1[addr_cap]) : 9'd0;
      if (stall_at >= 0 && !stall_used && pidx == stall_at) begin
        stall_used = 1; stall_left = 5;
      end
      stalled = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      if (intra) begin
        pred_valid = 1'($urandom_range(0, 1));
        pred_data  = 16'($urandom);
      end else begin
        pred_valid = stalled ? 1'b0 : (pv_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        pred_data  = (pidx < 32) ? 16'(ph[pidx] * 256 + pl[pidx]) : 16'($urandom);
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      softreset = (abort_at >= 0) && (nacc == abort_at);
      @(negedge clk);
      if (first_valid < 0 && out_valid) first_valid = cyc;
      if (intra && pred_ready) bad_pr++;
      if (stalled) begin
        stall_addr.push_back(int'(pixel_addr));
        if (pred_ready) stall_pr++;
      end
      if (pred_valid && pred_ready) begin
        iss.push_back(int'(pixel_addr));
        pidx++;
      end
      if (hold && (!out_valid || out_data !== hd || out_last !== hl)) stab_bad++;
      hold = out_valid && !out_ready; hd = out_data; hl = out_last;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_l.push_back(out_last);
        if (first_acc < 0) first_acc = cyc;
        if (out_last) last_cyc = cyc;
        nacc++;
      end
      if (!intra && pidx - nacc > max_occ) max_occ = pidx - nacc;
      if (done) begin
        done_cnt++; done_cyc = cyc; busy_at_done = int'(busy);
      end else if (done_cnt == 0 && !busy) busy_gap++;
      addr_cap = int'(pixel_addr); coded_cap = pixel_coded;
      if (softreset || (done_cnt > 0 && cyc == done_cyc + 2)) begin
        finished = 1;
        break;
      end
    end
    timeout = !finished;
    blk_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (pixel_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", pixel_addr); end
    total++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0) begin
      bad++; $display("FAIL reset_out got v=%b d=%h l=%b exp 0/0000/0", out_valid, out_data, out_last); end
    total++; if (pred_ready !== 1'b0 || done !== 1'b0 || pixel_coded !== 1'b0) begin
      bad++; $display("FAIL reset_misc got pr=%b done=%b pc=%b exp 0", pred_ready, done, pixel_coded); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_intra();
    for (int k = 0; k < 32; k++) begin res0[k] = 100; res1[k] = -5; pl[k] = 77; ph[k] = 200; end
    run_block(1, 1, 0, 0, -1, -1, 0);
    total++; if (timeout) begin bad++; $display("FAIL intra_timeout got=timeout exp=done"); end
    total++; if (got_d.size() != 32) begin bad++; $display("FAIL intra_count got=%0d exp=32", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 32; k++) begin
      total++; if (got_d[k] !== 16'h0064) begin bad++; $display("FAIL intra_word%0d got=%h exp=0064", k, got_d[k]); end
      total++; if (got_l[k] !== (k == 31)) begin bad++; $display("FAIL intra_last%0d got=%b exp=%b", k, got_l[k], k == 31); end
    end
    // blk_start cycle, then the issue cycle, then RD_LAT before the word lands in the buffer
    total++; if (first_valid != 3) begin bad++; $display("FAIL intra_first_valid got=%0d exp=3", first_valid); end
    total++; if (last_cyc - first_acc != 31) begin bad++; $display("FAIL intra_rate got=%0d exp=31", last_cyc - first_acc); end
    total++; if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
      bad++; $display("FAIL intra_done got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", done_cnt, done_cyc, last_cyc + 1); end
    total++; if (busy_at_done != 0 || busy_gap != 0) begin
      bad++; $display("FAIL intra_busy got at_done=%0d gap=%0d exp 0/0", busy_at_done, busy_gap); end
    total++; if (bad_pr != 0) begin bad++; $display("FAIL intra_pred_ready got=%0d exp=0", bad_pr); end
  endtask

  task automatic test_pred_clip();
    for (int k = 0; k < 32; k++) begin
      if (k < 16) begin res0[k] = -30; res1[k] = 20; pl[k] = 8'h10; ph[k] = 8'hF0; end
      else begin res0[k] = 0; res1[k] = 0; pl[k] = 8'h80; ph[k] = 8'h80; end
    end
    run_block(0, 1, 0, 0, -1, -1, 0);
    total++; if (got_d.size() != 32 || timeout) begin bad++; $display("FAIL pred_count got=%0d exp=32", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 32; k++) begin
      total++; if (got_d[k] !== model_word(k, 0, 1)) begin
        bad++; $display("FAIL pred_word%0d got=%h exp=%h", k, got_d[k], model_word(k, 0, 1)); end
    end
    if (got_d.size() == 32) begin
      total++; if (got_d[0] !== 16'hFF00) begin bad++; $display("FAIL pred_sat got=%h exp=ff00", got_d[0]); end
      total++; if (got_d[31] !== 16'h8080) begin bad++; $display("FAIL pred_pass got=%h exp=8080", got_d[31]); end
    end
    total++; if (last_cyc - first_acc != 31) begin bad++; $display("FAIL pred_rate got=%0d exp=31", last_cyc - first_acc); end
  endtask

  task automatic test_backpressure();
    fill_random();
    run_block(0, 1, 1, 0, -1, -1, 0);
    total++; if (got_d.size() != 32 || timeout) begin bad++; $display("FAIL bp_count got=%0d exp=32", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 32; k++) begin
      total++; if (got_d[k] !== model_word(k, 0, 1)) begin
        bad++; $display("FAIL bp_word%0d got=%h exp=%h", k, got_d[k], model_word(k, 0, 1)); end
    end
    for (int k = 0; k < iss.size(); k++) begin
      total++; if (iss[k] != k) begin bad++; $display("FAIL bp_addr%0d got=%0d exp=%0d", k, iss[k], k); end
    end
    total++; if (stab_bad != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_bad); end
    total++; if (max_occ > 2) begin bad++; $display("FAIL bp_occupancy got=%0d exp<=2", max_occ); end
  endtask

  task automatic test_pred_stall();
    fill_random();
    run_block(0, 1, 0, 0, 10, -1, 0);
    total++; if (got_d.size() != 32 || timeout) begin bad++; $display("FAIL stall_count got=%0d exp=32", got_d.size()); end
    total++; if (stall_addr.size() != 5) begin bad++; $display("FAIL stall_len got=%0d exp=5", stall_addr.size()); end
    foreach (stall_addr[k]) begin
      total++; if (stall_addr[k] != 10) begin bad++; $display("FAIL stall_frozen%0d got=%0d exp=10", k, stall_addr[k]); end
    end
    total++; if (stall_pr != 0) begin bad++; $display("FAIL stall_pred_ready got=%0d exp=0", stall_pr); end
    for (int k = 0; k < iss.size(); k++) begin
      total++; if (iss[k] != k) begin bad++; $display("FAIL stall_addr%0d got=%0d exp=%0d", k, iss[k], k); end
    end
    for (int k = 0; k < got_d.size() && k < 32; k++) begin
      total++; if (got_d[k] !== model_word(k, 0, 1)) begin
        bad++; $display("FAIL stall_word%0d got=%h exp=%h", k, got_d[k], model_word(k, 0, 1)); end
    end
  endtask

  task automatic test_random();
    bit intra, coded;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      intra = 1'($urandom_range(0, 1));
      coded = (it == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      run_block(intra, coded, 2, 1, -1, -1, 0);
      total++; if (got_d.size() != 32 || timeout) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=32", it, got_d.size()); end
      for (int k = 0; k < got_d.size() && k < 32; k++) begin
        total++; if (got_d[k] !== model_word(k, intra, coded) || got_l[k] !== (k == 31)) begin
          bad++; $display("FAIL rnd%0d_word%0d got=%h/%b exp=%h/%b", it, k, got_d[k], got_l[k], model_word(k, intra, coded), k == 31); end
      end
      total++; if (stab_bad != 0 || max_occ > 2) begin
        bad++; $display("FAIL rnd%0d_flow got stab=%0d occ=%0d exp 0/<=2", it, stab_bad, max_occ); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL rnd%0d_done got=%0d exp=1", it, done_cnt); end
    end
  endtask

  task automatic test_abort_restart();
    fill_random();
    run_block(0, 1, 0, 0, -1, 12, 1);
    total++; if (timeout) begin bad++; $display("FAIL abort_timeout got=timeout exp=abort"); end
    for (int k = 0; k < iss.size(); k++) begin
      total++; if (iss[k] != k) begin bad++; $display("FAIL abort_addr%0d got=%0d exp=%0d", k, iss[k], k); end
    end
    total++; if (busy_gap != 0 || done_cnt != 0) begin
      bad++; $display("FAIL abort_busy got gap=%0d done=%0d exp 0/0", busy_gap, done_cnt); end
    @(posedge clk); #1;
    softreset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || pixel_coded !== 1'b0 || pixel_addr !== 5'd0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_state got busy=%b pc=%b addr=%0d done=%b exp 0", busy, pixel_coded, pixel_addr, done); end
    total++; if (pred_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0) begin
      bad++; $display("FAIL abort_out got pr=%b v=%b d=%h l=%b exp 0", pred_ready, out_valid, out_data, out_last); end
    fill_random();
    run_block(0, 1, 2, 1, -1, -1, 0);
    total++; if (got_d.size() != 32 || timeout) begin bad++; $display("FAIL restart_count got=%0d exp=32", got_d.size()); end
    for (int k = 0; k < iss.size(); k++) begin
      total++; if (iss[k] != k) begin bad++; $display("FAIL restart_addr%0d got=%0d exp=%0d", k, iss[k], k); end
    end
    for (int k = 0; k < got_d.size() && k < 32; k++) begin
      total++; if (got_d[k] !== model_word(k, 0, 1)) begin
        bad++; $display("FAIL restart_word%0d got=%h exp=%h", k, got_d[k], model_word(k, 0, 1)); end
    end
  endtask

  initial begin
    reset = 1'b1; softreset = 1'b0; blk_start = 1'b0; blk_coded = 1'b0; blk_intra = 1'b0;
    pixel_data0 = 9'd0; pixel_data1 = 9'd0; pred_valid = 1'b0; pred_data = 16'h0; out_ready = 1'b1;
    test_reset();
    test_intra();
    test_pred_clip();
    test_backpressure();
    test_pred_stall();
    test_random();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
